// File: rtl/mips_pkg.sv
// Shared constants for the MIPS cores: opcodes, funct codes, ALU encodings, FSM states.
package mips_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned STATE_W = 4;

  // Opcodes of the supported subset
  localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OP_W-1:0] OP_LW    = 6'd35;
  localparam logic [OP_W-1:0] OP_SW    = 6'd43;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
  localparam logic [OP_W-1:0] OP_J     = 6'd2;

  // R-type funct codes
  localparam logic [OP_W-1:0] FN_ADD = 6'd32;
  localparam logic [OP_W-1:0] FN_SUB = 6'd34;
  localparam logic [OP_W-1:0] FN_AND = 6'd36;
  localparam logic [OP_W-1:0] FN_OR  = 6'd37;

  // ALU operation encodings
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;

  // Multi-cycle FSM state encodings (visible on the debug port)
  localparam logic [STATE_W-1:0] S_FETCH    = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE   = 4'd1;
  localparam logic [STATE_W-1:0] S_MEM_ADDR = 4'd2;
  localparam logic [STATE_W-1:0] S_MEM_RD   = 4'd3;
  localparam logic [STATE_W-1:0] S_MEM_WB   = 4'd4;
  localparam logic [STATE_W-1:0] S_MEM_WR   = 4'd5;
  localparam logic [STATE_W-1:0] S_EXEC     = 4'd6;
  localparam logic [STATE_W-1:0] S_R_WB     = 4'd7;
  localparam logic [STATE_W-1:0] S_BRANCH   = 4'd8;
  localparam logic [STATE_W-1:0] S_JUMP     = 4'd9;
  localparam logic [STATE_W-1:0] S_TRAP     = 4'd10;

endpackage

// File: rtl/mips_alu_dec.sv
// Funct-field ALU decoder, shared by the single- and multi-cycle cores.
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [OP_W-1:0]  funct_i,
  output logic [ALU_W-1:0] alu_ctrl_o,
  output logic             legal_o
);

  // Map funct to ALU op; unknown functs fall back to add and flag illegal
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    legal_o    = 1'b0;
    case (funct_i)
      FN_ADD: begin alu_ctrl_o = ALU_ADD; legal_o = 1'b1; end
      FN_SUB: begin alu_ctrl_o = ALU_SUB; legal_o = 1'b1; end
      FN_AND: begin alu_ctrl_o = ALU_AND; legal_o = 1'b1; end
      FN_OR:  begin alu_ctrl_o = ALU_OR;  legal_o = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multi_ctrl.sv
// Main control FSM of the multi-cycle MIPS core, with retire counter and halt flag.
module mips_multi_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALU_W-1:0]   alu_ctrl,
  output logic [1:0]         pc_source,
  output logic               halted,
  output logic [CNT_W-1:0]   instr_count,
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [ALU_W-1:0]   alu_op_q, alu_op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               retire_c;
  logic [ALU_W-1:0]   dec_alu_c;
  logic               dec_legal_c;

  mips_alu_dec u_alu_dec (
    .funct_i    (funct),
    .alu_ctrl_o (dec_alu_c),
    .legal_o    (dec_legal_c)
  );

  // Next state and control outputs; everything is held at idle values while in reset
  always_comb begin
    state_d    = state_q;
    alu_op_d   = alu_op_q;
    retire_c   = 1'b0;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    pc_source  = 2'b00;
    halted     = 1'b0;
    if (rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          pc_en     = mem_ready;
          ir_write  = mem_ready;
          if (mem_ready) state_d = S_DECODE;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          alu_op_d  = dec_alu_c;
          if (opcode == OP_RTYPE && dec_legal_c)     state_d = S_EXEC;
          else if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEM_ADDR;
          else if (opcode == OP_BEQ)                  state_d = S_BRANCH;
          else if (opcode == OP_J)                    state_d = S_JUMP;
          else                                        state_d = S_TRAP;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_ctrl  = alu_op_q;
          state_d   = S_R_WB;
        end
        S_R_WB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
          retire_c  = 1'b1;
          state_d   = S_FETCH;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) state_d = S_MEM_WB;
        end
        S_MEM_WB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          retire_c   = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEM_WR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
          if (mem_ready) begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_ctrl  = ALU_SUB;
          pc_source = 2'b01;
          pc_en     = zero;
          retire_c  = 1'b1;
          state_d   = S_FETCH;
        end
        S_JUMP: begin
          pc_source = 2'b10;
          pc_en     = 1'b1;
          retire_c  = 1'b1;
          state_d   = S_FETCH;
        end
        S_TRAP: halted = 1'b1;
        default: state_d = S_TRAP;
      endcase
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_comb begin
    cnt_d = cnt_q;
    if (retire_c) cnt_d = cnt_q + CNT_W'(1);
  end

  // State, registered ALU op and counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      alu_op_q <= ALU_ADD;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
      cnt_q    <= cnt_d;
    end
  end

  assign instr_count = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_multi_ctrl.sv
// Directed bench for the multi-cycle control FSM: per-cycle vector table plus corner sequences.
module tb_mips_multi_ctrl;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       opcode, funct;
  logic             zero, mem_ready;
  logic             pc_en, iord, mem_read, mem_write, ir_write;
  logic             reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, pc_source;
  logic [2:0]       alu_ctrl;
  logic             halted;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state;
  logic [15:0]      ctrl;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mips_multi_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_source(pc_source),
    .halted(halted), .instr_count(instr_count), .state(state)
  );

  // {pc_en,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_ctrl,pc_source}
  assign ctrl = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_source};

  // Hand-derived control words
  localparam logic [15:0] C_FETCH_R = 16'hA828;
  localparam logic [15:0] C_FETCH_W = 16'h2028;
  localparam logic [15:0] C_DECODE  = 16'h0068;
  localparam logic [15:0] C_EX_ADD  = 16'h0088;
  localparam logic [15:0] C_EX_SUB  = 16'h0098;
  localparam logic [15:0] C_EX_AND  = 16'h0080;
  localparam logic [15:0] C_EX_OR   = 16'h0084;
  localparam logic [15:0] C_R_WB    = 16'h0508;
  localparam logic [15:0] C_MADDR   = 16'h00C8;
  localparam logic [15:0] C_MRD     = 16'h6008;
  localparam logic [15:0] C_MWB     = 16'h0308;
  localparam logic [15:0] C_MWR     = 16'h5008;
  localparam logic [15:0] C_BR_T    = 16'h8099;
  localparam logic [15:0] C_BR_N    = 16'h0099;
  localparam logic [15:0] C_JUMP    = 16'h800A;
  localparam logic [15:0] C_IDLE    = 16'h0008;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [3:0]  exp_state;
    logic [15:0] exp_ctrl;
    logic        exp_halt;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic rdy, input logic [3:0] st, input logic [15:0] c,
                     input logic [7:0] cnt);
    vec_t v;
    v = '{op: op, fn: fn, z: z, rdy: rdy, exp_state: st, exp_ctrl: c,
          exp_halt: 1'b0, exp_cnt: cnt};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy);
    opcode = op; funct = fn; zero = z; mem_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Run one instruction with mem_ready=1 and no per-cycle checks
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      drive(op, fn, 1'b0, 1'b1);
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(6'd0, 6'd0, 1'b0, 1'b1);
    @(negedge clk);

    // Reset state
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctrl",  32'(ctrl), 32'(C_IDLE));
    chk("rst_halt",  32'(halted), 32'd0);
    chk("rst_cnt",   32'(instr_count), 32'd0);
    rst = 1'b1;

    // ADD
    add(6'd0, 6'd32, 0, 1, 4'd0, C_FETCH_R, 8'd0);
    add(6'd0, 6'd32, 0, 1, 4'd1, C_DECODE,  8'd0);
    add(6'd0, 6'd32, 0, 1, 4'd6, C_EX_ADD,  8'd0);
    add(6'd0, 6'd32, 0, 1, 4'd7, C_R_WB,    8'd0);
    // SUB with one fetch wait
    add(6'd0, 6'd34, 0, 0, 4'd0, C_FETCH_W, 8'd1);
    add(6'd0, 6'd34, 0, 1, 4'd0, C_FETCH_R, 8'd1);
    add(6'd0, 6'd34, 0, 1, 4'd1, C_DECODE,  8'd1);
    add(6'd0, 6'd34, 0, 1, 4'd6, C_EX_SUB,  8'd1);
    add(6'd0, 6'd34, 0, 1, 4'd7, C_R_WB,    8'd1);
    // AND
    add(6'd0, 6'd36, 0, 1, 4'd0, C_FETCH_R, 8'd2);
    add(6'd0, 6'd36, 0, 1, 4'd1, C_DECODE,  8'd2);
    add(6'd0, 6'd36, 0, 1, 4'd6, C_EX_AND,  8'd2);
    add(6'd0, 6'd36, 0, 1, 4'd7, C_R_WB,    8'd2);
    // OR
    add(6'd0, 6'd37, 0, 1, 4'd0, C_FETCH_R, 8'd3);
    add(6'd0, 6'd37, 0, 1, 4'd1, C_DECODE,  8'd3);
    add(6'd0, 6'd37, 0, 1, 4'd6, C_EX_OR,   8'd3);
    add(6'd0, 6'd37, 0, 1, 4'd7, C_R_WB,    8'd3);
    // LW with two read waits: 7 cycles
    add(6'd35, 6'd0, 0, 1, 4'd0, C_FETCH_R, 8'd4);
    add(6'd35, 6'd0, 0, 1, 4'd1, C_DECODE,  8'd4);
    add(6'd35, 6'd0, 0, 1, 4'd2, C_MADDR,   8'd4);
    add(6'd35, 6'd0, 0, 0, 4'd3, C_MRD,     8'd4);
    add(6'd35, 6'd0, 0, 0, 4'd3, C_MRD,     8'd4);
    add(6'd35, 6'd0, 0, 1, 4'd3, C_MRD,     8'd4);
    add(6'd35, 6'd0, 0, 1, 4'd4, C_MWB,     8'd4);
    // SW with one write wait
    add(6'd43, 6'd0, 0, 1, 4'd0, C_FETCH_R, 8'd5);
    add(6'd43, 6'd0, 0, 1, 4'd1, C_DECODE,  8'd5);
    add(6'd43, 6'd0, 0, 1, 4'd2, C_MADDR,   8'd5);
    add(6'd43, 6'd0, 0, 0, 4'd5, C_MWR,     8'd5);
    add(6'd43, 6'd0, 0, 1, 4'd5, C_MWR,     8'd5);
    // BEQ taken, then not taken
    add(6'd4, 6'd0, 1, 1, 4'd0, C_FETCH_R, 8'd6);
    add(6'd4, 6'd0, 1, 1, 4'd1, C_DECODE,  8'd6);
    add(6'd4, 6'd0, 1, 1, 4'd8, C_BR_T,    8'd6);
    add(6'd4, 6'd0, 0, 1, 4'd0, C_FETCH_R, 8'd7);
    add(6'd4, 6'd0, 0, 1, 4'd1, C_DECODE,  8'd7);
    add(6'd4, 6'd0, 0, 1, 4'd8, C_BR_N,    8'd7);
    // J
    add(6'd2, 6'd0, 0, 1, 4'd0, C_FETCH_R, 8'd8);
    add(6'd2, 6'd0, 0, 1, 4'd1, C_DECODE,  8'd8);
    add(6'd2, 6'd0, 0, 1, 4'd9, C_JUMP,    8'd8);
    // Back in fetch after nine retires
    add(6'd0, 6'd0, 0, 0, 4'd0, C_FETCH_W, 8'd9);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy);
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
      chk($sformatf("v%0d_ctrl", i),  32'(ctrl), 32'(vecs[i].exp_ctrl));
      chk($sformatf("v%0d_halt", i),  32'(halted), 32'(vecs[i].exp_halt));
      chk($sformatf("v%0d_cnt", i),   32'(instr_count), 32'(vecs[i].exp_cnt));
      if (mem_read && mem_write) chk($sformatf("v%0d_rdwr", i), 32'd1, 32'd0);
      tick();
    end

    // Reset asserted mid-store while memory is stalled
    run_instr(6'd43, 6'd0, 3);
    drive(6'd43, 6'd0, 1'b0, 1'b0);
    chk("mwr_state", 32'(state), 32'd5);
    chk("mwr_write", 32'(mem_write), 32'd1);
    rst = 1'b0;
    #1;
    chk("mwr_rst_write", 32'(mem_write), 32'd0);
    chk("mwr_rst_state", 32'(state), 32'd0);
    chk("mwr_rst_cnt",   32'(instr_count), 32'd0);
    tick();
    rst = 1'b1;
    drive(6'd0, 6'd32, 1'b0, 1'b1);
    chk("rel_state", 32'(state), 32'd0);
    chk("rel_ctrl",  32'(ctrl), 32'(C_FETCH_R));
    tick();
    chk("rel_decode", 32'(state), 32'd1);
    tick();
    tick();
    tick();
    chk("rel_cnt", 32'(instr_count), 32'd1);

    // Unsupported opcode (ADDI) traps and stays trapped
    run_instr(6'd8, 6'd0, 2);
    for (int c = 0; c < 10; c++) begin
      drive(6'd0, 6'd32, 1'b1, 1'b1);
      chk($sformatf("trap%0d_state", c), 32'(state), 32'd10);
      chk($sformatf("trap%0d_ctrl", c),  32'(ctrl), 32'(C_IDLE));
      chk($sformatf("trap%0d_halt", c),  32'(halted), 32'd1);
      chk($sformatf("trap%0d_cnt", c),   32'(instr_count), 32'd1);
      tick();
    end
    rst = 1'b0;
    #1;
    chk("trap_rst_halt", 32'(halted), 32'd0);
    tick();
    rst = 1'b1;

    // Counter wrap: 255 jumps, then a store retires as number 256
    for (int k = 0; k < 255; k++) run_instr(6'd2, 6'd0, 3);
    drive(6'd43, 6'd0, 1'b0, 1'b1);
    chk("wrap_pre", 32'(instr_count), 32'd255);
    run_instr(6'd43, 6'd0, 4);
    drive(6'd0, 6'd0, 1'b0, 1'b0);
    chk("wrap_cnt",   32'(instr_count), 32'd0);
    chk("wrap_state", 32'(state), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
